// File: rtl/imem_loader_if.sv
// Byte-stream input and instruction-memory write port of the program loader.
// The loader sits on the slave modport; the byte source and the memory form the master side.
interface imem_loader_if #(
    parameter int ADDR_W = 10
);
    logic              in_valid;
    logic [7:0]        in_data;
    logic              in_ready;
    logic              imem_we;
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_wdata;

    modport slave (
        input  in_valid,
        input  in_data,
        output in_ready,
        output imem_we,
        output imem_addr,
        output imem_wdata
    );

    modport master (
        output in_valid,
        output in_data,
        input  in_ready,
        input  imem_we,
        input  imem_addr,
        input  imem_wdata
    );
endinterface

// File: rtl/imem_loader.sv
// Framed byte-stream program loader: assembles little-endian words into instruction memory
// from address 0 and holds the CPU until a frame ends with a good checksum.
module imem_loader #(
    parameter int         ADDR_W    = 10,
    parameter int         MAX_WORDS = 1024,
    parameter logic [7:0] SYNC_BYTE = 8'hA5
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            restart,
    imem_loader_if.slave    bus,
    output logic            cpu_hold,
    output logic            done,
    output logic            error,
    output logic [ADDR_W:0] word_cnt
);
    typedef enum logic [2:0] {IDLE, LEN_LO, LEN_HI, DATA, CHK, DONE, ERR} state_t;

    state_t            state, state_nx;
    logic [7:0]        len_lo, len_lo_nx;
    logic [15:0]       len, len_nx;
    logic [7:0]        checksum, checksum_nx;
    logic [1:0]        byte_idx, byte_idx_nx;
    logic [23:0]       asm_word, asm_word_nx;
    logic [ADDR_W:0]   word_cnt_nx;
    logic              imem_we_nx;
    logic [ADDR_W-1:0] imem_addr_nx;
    logic [31:0]       imem_wdata_nx;
    logic              accept;
    logic [15:0]       len_in;
    logic [ADDR_W:0]   word_cnt_inc;

    assign bus.in_ready = (state != DONE) && (state != ERR);
    assign accept       = bus.in_valid && bus.in_ready;
    assign len_in       = {bus.in_data, len_lo};
    assign word_cnt_inc = word_cnt + {{ADDR_W{1'b0}}, 1'b1};

    // Next-state and next-register values; the fourth byte of a word registers the write
    // so imem_we follows the accepting edge by exactly one cycle.
    always_comb begin
        state_nx      = state;
        len_lo_nx     = len_lo;
        len_nx        = len;
        checksum_nx   = checksum;
        byte_idx_nx   = byte_idx;
        asm_word_nx   = asm_word;
        word_cnt_nx   = word_cnt;
        imem_we_nx    = 1'b0;
        imem_addr_nx  = bus.imem_addr;
        imem_wdata_nx = bus.imem_wdata;

        unique case (state)
            IDLE: begin
                if (accept && (bus.in_data == SYNC_BYTE)) begin
                    checksum_nx = '0;
                    word_cnt_nx = '0;
                    byte_idx_nx = '0;
                    state_nx    = LEN_LO;
                end
            end
            LEN_LO: begin
                if (accept) begin
                    len_lo_nx   = bus.in_data;
                    checksum_nx = checksum ^ bus.in_data;
                    state_nx    = LEN_HI;
                end
            end
            LEN_HI: begin
                if (accept) begin
                    len_nx      = len_in;
                    checksum_nx = checksum ^ bus.in_data;
                    if (32'(len_in) > 32'(MAX_WORDS)) begin
                        state_nx = ERR;
                    end else if (len_in == 16'd0) begin
                        state_nx = CHK;
                    end else begin
                        state_nx = DATA;
                    end
                end
            end
            DATA: begin
                if (accept) begin
                    checksum_nx = checksum ^ bus.in_data;
                    byte_idx_nx = byte_idx + 2'd1;
                    unique case (byte_idx)
                        2'd0: asm_word_nx[7:0]   = bus.in_data;
                        2'd1: asm_word_nx[15:8]  = bus.in_data;
                        2'd2: asm_word_nx[23:16] = bus.in_data;
                        default: begin
                            imem_we_nx    = 1'b1;
                            imem_wdata_nx = {bus.in_data, asm_word};
                            imem_addr_nx  = word_cnt[ADDR_W-1:0];
                            word_cnt_nx   = word_cnt_inc;
                            if (32'(word_cnt_inc) == 32'(len)) begin
                                state_nx = CHK;
                            end
                        end
                    endcase
                end
            end
            CHK: begin
                if (accept) begin
                    state_nx = (bus.in_data == checksum) ? DONE : ERR;
                end
            end
            DONE, ERR: begin
                if (restart) begin
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    // Status flags are registered from the next state so cpu_hold drops on the edge done rises.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= IDLE;
            len_lo         <= '0;
            len            <= '0;
            checksum       <= '0;
            byte_idx       <= '0;
            asm_word       <= '0;
            word_cnt       <= '0;
            bus.imem_we    <= 1'b0;
            bus.imem_addr  <= '0;
            bus.imem_wdata <= '0;
            cpu_hold       <= 1'b1;
            done           <= 1'b0;
            error          <= 1'b0;
        end else begin
            state          <= state_nx;
            len_lo         <= len_lo_nx;
            len            <= len_nx;
            checksum       <= checksum_nx;
            byte_idx       <= byte_idx_nx;
            asm_word       <= asm_word_nx;
            word_cnt       <= word_cnt_nx;
            bus.imem_we    <= imem_we_nx;
            bus.imem_addr  <= imem_addr_nx;
            bus.imem_wdata <= imem_wdata_nx;
            cpu_hold       <= (state_nx != DONE);
            done           <= (state_nx == DONE);
            error          <= (state_nx == ERR);
        end
    end
endmodule

// File: tb/tb_imem_loader.sv
// Bench for imem_loader: frames go through a byte driver, and a frame-level reference model
// predicts every memory write (address, data, cycle) and the final load status.
module tb_imem_loader;
    localparam int         ADDR_W    = 10;
    localparam int         MAX_WORDS = 1024;
    localparam logic [7:0] SYNC      = 8'hA5;

    typedef struct {
        int          cyc;
        int          addr;
        logic [31:0] data;
    } wr_t;

    logic            clk;
    logic            rst_n;
    logic            restart;
    logic            cpu_hold;
    logic            done;
    logic            error;
    logic [ADDR_W:0] word_cnt;

    imem_loader_if #(.ADDR_W(ADDR_W)) bus_if ();

    imem_loader #(
        .ADDR_W(ADDR_W),
        .MAX_WORDS(MAX_WORDS),
        .SYNC_BYTE(SYNC)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .restart(restart),
        .bus(bus_if),
        .cpu_hold(cpu_hold),
        .done(done),
        .error(error),
        .word_cnt(word_cnt)
    );

    int         total = 0;
    int         bad = 0;
    int         cyc = 0;
    int         drvCyc = 0;
    wr_t        expQ[$];
    logic [7:0] frame[$];
    bit         expDone;
    bit         expErr;
    int         expCnt;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog got=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("[TB] FAIL %s got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Every observed write must be the next one the model predicted, on the predicted cycle.
    always @(negedge clk) begin
        wr_t e;
        if (rst_n && bus_if.imem_we) begin
            if (expQ.size() == 0) begin
                checkOutput("unexpected_write", 64'd1, 64'd0);
            end else begin
                e = expQ.pop_front();
                checkOutput("wr_addr", 64'(bus_if.imem_addr), 64'(e.addr));
                checkOutput("wr_data", 64'(bus_if.imem_wdata), 64'(e.data));
                checkOutput("wr_latency", 64'(cyc), 64'(e.cyc));
            end
        end
    end

    task automatic put(input logic [7:0] b);
        frame.push_back(b);
    endtask

    task automatic sendByte(input logic [7:0] b, input int gap);
        for (int g = 0; g < gap; g++) begin
            @(negedge clk);
            bus_if.in_valid = 1'b0;
        end
        @(negedge clk);
        bus_if.in_valid = 1'b1;
        bus_if.in_data  = b;
        drvCyc = cyc;
    endtask

    // Model: locate the first sync byte, read the length, then derive the words, the checksum
    // verdict and the word count straight from the byte positions of the frame.
    task automatic applyStimulus(input int maxGap);
        int          n;
        int          s;
        int          first;
        int          last;
        bit          lenOk;
        logic [15:0] len;
        logic [7:0]  x;
        wr_t         e;
        n = frame.size();
        s = -1;
        for (int i = 0; i < n; i++) begin
            if (s < 0 && frame[i] == SYNC) s = i;
        end
        expDone = 0;
        expErr  = 0;
        expCnt  = 0;
        lenOk   = 0;
        first   = 0;
        last    = 0;
        if (s >= 0 && s + 2 < n) begin
            len   = {frame[s+2], frame[s+1]};
            lenOk = (int'(len) <= MAX_WORDS);
            first = s + 3;
            last  = s + 3 + 4 * int'(len);
            if (!lenOk) begin
                expErr = 1;
            end else begin
                expCnt = int'(len);
                if (last < n) begin
                    x = frame[s+1] ^ frame[s+2];
                    for (int i = first; i < last; i++) x ^= frame[i];
                    expDone = (frame[last] == x);
                    expErr  = !expDone;
                end
            end
        end
        for (int i = 0; i < n; i++) begin
            sendByte(frame[i], (maxGap > 0) ? int'($urandom_range(0, maxGap)) : 0);
            if (lenOk && i >= first && i < last && ((i - first) % 4 == 3)) begin
                e.cyc  = drvCyc + 1;
                e.addr = (i - first) / 4;
                e.data = {frame[i], frame[i-1], frame[i-2], frame[i-3]};
                expQ.push_back(e);
            end
        end
        @(negedge clk);
        bus_if.in_valid = 1'b0;
    endtask

    task automatic checkStatus(input string name);
        @(negedge clk);
        @(negedge clk);
        checkOutput({name, "_done"}, 64'(done), 64'(expDone));
        checkOutput({name, "_error"}, 64'(error), 64'(expErr));
        checkOutput({name, "_cpu_hold"}, 64'(cpu_hold), 64'(!expDone));
        checkOutput({name, "_word_cnt"}, 64'(word_cnt), 64'(expCnt));
        checkOutput({name, "_in_ready"}, 64'(bus_if.in_ready), 64'(!(expDone || expErr)));
        checkOutput({name, "_pending"}, 64'(expQ.size()), 64'd0);
    endtask

    task automatic doRestart(input string name);
        @(negedge clk);
        restart = 1'b1;
        @(negedge clk);
        restart = 1'b0;
        checkOutput({name, "_rs_done"}, 64'(done), 64'd0);
        checkOutput({name, "_rs_error"}, 64'(error), 64'd0);
        checkOutput({name, "_rs_cpu_hold"}, 64'(cpu_hold), 64'd1);
        checkOutput({name, "_rs_in_ready"}, 64'(bus_if.in_ready), 64'd1);
        checkOutput({name, "_rs_word_cnt"}, 64'(word_cnt), 64'(expCnt));
    endtask

    task automatic checkReset(input string name);
        checkOutput({name, "_in_ready"}, 64'(bus_if.in_ready), 64'd1);
        checkOutput({name, "_imem_we"}, 64'(bus_if.imem_we), 64'd0);
        checkOutput({name, "_imem_addr"}, 64'(bus_if.imem_addr), 64'd0);
        checkOutput({name, "_imem_wdata"}, 64'(bus_if.imem_wdata), 64'd0);
        checkOutput({name, "_cpu_hold"}, 64'(cpu_hold), 64'd1);
        checkOutput({name, "_done"}, 64'(done), 64'd0);
        checkOutput({name, "_error"}, 64'(error), 64'd0);
        checkOutput({name, "_word_cnt"}, 64'(word_cnt), 64'd0);
    endtask

    initial begin
        logic [7:0] b;
        logic [7:0] x;
        int         len;
        rst_n           = 1'b0;
        restart         = 1'b0;
        bus_if.in_valid = 1'b0;
        bus_if.in_data  = 8'h00;
        repeat (3) @(negedge clk);
        checkReset("por");
        rst_n = 1'b1;

        frame.delete();
        put(8'hA5); put(8'h02); put(8'h00); put(8'h13); put(8'h00); put(8'h00);
        put(8'h00); put(8'h6F); put(8'h00); put(8'h00); put(8'h00); put(8'h7E);
        applyStimulus(0);
        checkStatus("good_frame");
        doRestart("good_frame");

        frame[11] = 8'h7F;
        applyStimulus(0);
        checkStatus("bad_chk");
        doRestart("bad_chk");

        // Reset mid-word after two data bytes, then reload the whole frame from address 0.
        frame.delete();
        put(8'hA5); put(8'h01); put(8'h00); put(8'h13); put(8'h00);
        applyStimulus(0);
        rst_n = 1'b0;
        #1;
        checkReset("mid_reset");
        @(negedge clk);
        rst_n = 1'b1;
        checkOutput("mid_reset_pending", 64'(expQ.size()), 64'd0);
        put(8'h00); put(8'h00); put(8'h12);
        applyStimulus(2);
        checkStatus("reload");
        doRestart("reload");

        frame.delete();
        put(8'h00); put(8'hFF); put(8'h13); put(8'hA5); put(8'h00); put(8'h00); put(8'h00);
        applyStimulus(1);
        checkStatus("garbage");
        doRestart("garbage");

        frame.delete();
        put(8'hA5); put(8'h00); put(8'h04);
        x = 8'h04;
        for (int i = 0; i < 4 * MAX_WORDS; i++) begin
            b = 8'($urandom);
            put(b);
            x ^= b;
        end
        put(x);
        applyStimulus(0);
        checkStatus("max_len");
        doRestart("max_len");

        frame.delete();
        put(8'hA5); put(8'h01); put(8'h04); put(8'h11); put(8'h22); put(8'hA5); put(8'h33);
        applyStimulus(0);
        checkStatus("over_len");
        doRestart("over_len");

        frame.delete();
        put(8'hA5); put(8'h01); put(8'h00);
        x = 8'h01;
        for (int i = 0; i < 4; i++) begin
            b = 8'($urandom);
            put(b);
            x ^= b;
        end
        put(x);
        applyStimulus(5);
        checkStatus("gapped");
        doRestart("gapped");

        for (int t = 0; t < 14; t++) begin
            frame.delete();
            for (int g = int'($urandom_range(0, 3)); g > 0; g--) begin
                do b = 8'($urandom); while (b == SYNC);
                put(b);
            end
            len = int'($urandom_range(0, 6));
            put(SYNC); put(8'(len)); put(8'h00);
            x = 8'(len);
            for (int i = 0; i < 4 * len; i++) begin
                b = 8'($urandom);
                put(b);
                x ^= b;
            end
            if ($urandom_range(0, 3) == 0) x ^= 8'(1 + $urandom_range(0, 254));
            put(x);
            applyStimulus(int'($urandom_range(0, 3)));
            checkStatus("rand");
            doRestart("rand");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
